ft600_bus_scheduler: RTL and testbench

- Owns the FT600 245-synchronous FIFO bus in the `i_ft_clk` domain.
- Arbitrates bus ownership between the host->FPGA RX path (pushes into an on-chip sink) and the FPGA->host TX path (pops from an on-chip source).
- Sequences OE_n/RD_n/WR_n, the data/BE drive enable and the bus turnaround, with bounded bursts and round-robin fairness.
- The top level keeps the inout tristate buffers and drives them from `o_ft_drive`.

---
 rtl/ft600_pkg.sv | 19 +
 rtl/ft600_tx_hold.sv | 42 ++++
 rtl/ft600_bus_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_ft600_bus_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft600_pkg.sv
// Shared definitions for the FT600 245-synchronous FIFO bus scheduler.
package ft600_pkg;

  localparam int DATA_W          = 16;
  localparam int BE_W            = 2;
  // Sink raises afull with this many free slots left. That covers words
  // still in flight after the scheduler decides to stop reading.
  localparam int RX_AFULL_MARGIN = 4;
  localparam int CNT_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_OE   = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_TX_DATA = 3'd3,
    ST_TURN    = 3'd4
  } ft_state_e;

endpackage

// File: rtl/ft600_tx_hold.sv
// Single-entry holding register for the word currently offered on the FT600
// bus. A word stays here until the FT600 accepts it, so a burst cut short by
// txe_n resumes with the same word in the next TX burst.
module ft600_tx_hold
  import ft600_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic [BE_W-1:0]   be_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;

  // Load a popped source word, or release the entry once the FT600 takes it.
  // load and accept are mutually exclusive: a pop needs an empty entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
      be_q   <= be_i;
    end else if (accept_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign be_o   = be_q;

endmodule

// File: rtl/ft600_bus_scheduler.sv
// FT600 245-synchronous FIFO bus owner. Arbitrates the bus between the
// host->FPGA RX path and the FPGA->host TX path with bounded bursts,
// round-robin fairness and an idle turnaround gap between bursts.
//
// Handshakes:
//   FT600 RX : a word moves on every edge where rd_n==0 and rxf_n==0.
//   FT600 TX : a word moves on every edge where wr_n==0 and txe_n==0.
//   source   : o_tx_pop is combinational; the source drops its head word on
//              the edge where o_tx_pop==1 (i_tx_valid must already be high).
//   sink     : o_rx_valid is a one-cycle push; the sink has no ready, it
//              throttles with i_rx_afull instead.
module ft600_bus_scheduler
  import ft600_pkg::*;
#(
  parameter int MAX_BURST   = 512,
  parameter int TURN_CYCLES = 1
) (
  input  logic              i_ft_clk,
  input  logic              i_rst_n,
  input  logic              i_ft_rxf_n,
  input  logic              i_ft_txe_n,
  input  logic [DATA_W-1:0] i_ft_data,
  input  logic [BE_W-1:0]   i_ft_be,
  output logic [DATA_W-1:0] o_ft_data,
  output logic [BE_W-1:0]   o_ft_be,
  output logic              o_ft_drive,
  output logic              o_ft_oe_n,
  output logic              o_ft_rd_n,
  output logic              o_ft_wr_n,
  output logic [DATA_W-1:0] o_rx_data,
  output logic [BE_W-1:0]   o_rx_be,
  output logic              o_rx_valid,
  input  logic              i_rx_afull,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [BE_W-1:0]   i_tx_be,
  input  logic              i_tx_valid,
  output logic              o_tx_pop,
  output logic [2:0]        o_state
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BURST);
  localparam logic [2:0]       TURN_LAST = 3'(TURN_CYCLES - 1);

  ft_state_e         state_q;
  logic              oe_n_q, rd_n_q, wr_n_q, drive_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [BE_W-1:0]   rx_be_q;
  logic              rx_valid_q;
  logic              last_grant_rx_q;  // 0 = TX had the last burst
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        turn_cnt_q;

  logic [CNT_W-1:0]  cnt_inc;
  logic              rx_req, tx_req;
  logic              tx_pop, tx_accept;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [BE_W-1:0]   hold_be;

  assign cnt_inc   = cnt_q + 1'b1;
  assign rx_req    = !i_ft_rxf_n && !i_rx_afull;
  assign tx_req    = !i_ft_txe_n && (i_tx_valid || hold_full);
  assign tx_pop    = (state_q == ST_TX_DATA) && !hold_full && i_tx_valid &&
                     !i_ft_txe_n && (cnt_q < MAX_CNT);
  assign tx_accept = (state_q == ST_TX_DATA) && !wr_n_q && !i_ft_txe_n;

  ft600_tx_hold u_tx_hold (
    .clk_i    (i_ft_clk),
    .rst_ni   (i_rst_n),
    .load_i   (tx_pop),
    .accept_i (tx_accept),
    .data_i   (i_tx_data),
    .be_i     (i_tx_be),
    .full_o   (hold_full),
    .data_o   (hold_data),
    .be_o     (hold_be)
  );

  // Bus FSM: every strobe and enable is a register updated on the transition
  // that needs it, so nothing combinational reaches the FT600 pins.
  always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      oe_n_q          <= 1'b1;
      rd_n_q          <= 1'b1;
      wr_n_q          <= 1'b1;
      drive_q         <= 1'b0;
      rx_data_q       <= '0;
      rx_be_q         <= '0;
      rx_valid_q      <= 1'b0;
      last_grant_rx_q <= 1'b0;
      cnt_q           <= '0;
      turn_cnt_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_req && (!tx_req || !last_grant_rx_q)) begin
            state_q         <= ST_RX_OE;
            oe_n_q          <= 1'b0;
            last_grant_rx_q <= 1'b1;
          end else if (tx_req) begin
            state_q         <= ST_TX_DATA;
            drive_q         <= 1'b1;
            // A word left over from an interrupted burst goes out first.
            wr_n_q          <= !hold_full;
            last_grant_rx_q <= 1'b0;
          end
        end
        ST_RX_OE: begin
          state_q <= ST_RX_DATA;
          rd_n_q  <= 1'b0;
        end
        ST_RX_DATA: begin
          if (i_ft_rxf_n) begin
            state_q    <= ST_TURN;
            rd_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            turn_cnt_q <= '0;
          end else begin
            // rd_n is low, so the FT600 has presented this word: take it even
            // if afull just rose; the afull margin absorbs it.
            rx_data_q  <= i_ft_data;
            rx_be_q    <= i_ft_be;
            rx_valid_q <= 1'b1;
            cnt_q      <= cnt_inc;
            if (i_rx_afull || (cnt_inc == MAX_CNT)) begin
              state_q    <= ST_TURN;
              rd_n_q     <= 1'b1;
              oe_n_q     <= 1'b1;
              turn_cnt_q <= '0;
            end
          end
        end
        ST_TX_DATA: begin
          if (!wr_n_q) begin
            if (i_ft_txe_n) begin
              // Not accepted: the word stays in the hold register.
              state_q    <= ST_TURN;
              wr_n_q     <= 1'b1;
              drive_q    <= 1'b0;
              turn_cnt_q <= '0;
            end else begin
              cnt_q  <= cnt_inc;
              wr_n_q <= 1'b1;
              if (cnt_inc == MAX_CNT) begin
                state_q    <= ST_TURN;
                drive_q    <= 1'b0;
                turn_cnt_q <= '0;
              end
            end
          end else if (tx_pop) begin
            wr_n_q <= 1'b0;
          end else begin
            state_q    <= ST_TURN;
            drive_q    <= 1'b0;
            turn_cnt_q <= '0;
          end
        end
        ST_TURN: begin
          cnt_q <= '0;
          if (turn_cnt_q == TURN_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            turn_cnt_q <= turn_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ft_data  = hold_data;
  assign o_ft_be    = hold_be;
  assign o_ft_drive = drive_q;
  assign o_ft_oe_n  = oe_n_q;
  assign o_ft_rd_n  = rd_n_q;
  assign o_ft_wr_n  = wr_n_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_be    = rx_be_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_pop   = tx_pop;
  assign o_state    = state_q;

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Bench for ft600_bus_scheduler: an FT600 device model, a source and a sink
// around the DUT, with word-order scoreboards and burst bookkeeping.
module tb_ft600_bus_scheduler;
  import ft600_pkg::*;

  localparam int MAXB  = 4;
  localparam int TURNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst_n;
  always #5 clk = ~clk;

  logic              i_ft_rxf_n, i_ft_txe_n, i_rx_afull, i_tx_valid;
  logic [DATA_W-1:0] i_ft_data, i_tx_data;
  logic [BE_W-1:0]   i_ft_be, i_tx_be;
  logic [DATA_W-1:0] o_ft_data, o_rx_data;
  logic [BE_W-1:0]   o_ft_be, o_rx_be;
  logic              o_ft_drive, o_ft_oe_n, o_ft_rd_n, o_ft_wr_n;
  logic              o_rx_valid, o_tx_pop;
  logic [2:0]        o_state;

  ft600_bus_scheduler #(.MAX_BURST(MAXB), .TURN_CYCLES(TURNC)) dut (
    .i_ft_clk(clk), .i_rst_n(i_rst_n),
    .i_ft_rxf_n(i_ft_rxf_n), .i_ft_txe_n(i_ft_txe_n),
    .i_ft_data(i_ft_data), .i_ft_be(i_ft_be),
    .o_ft_data(o_ft_data), .o_ft_be(o_ft_be), .o_ft_drive(o_ft_drive),
    .o_ft_oe_n(o_ft_oe_n), .o_ft_rd_n(o_ft_rd_n), .o_ft_wr_n(o_ft_wr_n),
    .o_rx_data(o_rx_data), .o_rx_be(o_rx_be), .o_rx_valid(o_rx_valid),
    .i_rx_afull(i_rx_afull),
    .i_tx_data(i_tx_data), .i_tx_be(i_tx_be), .i_tx_valid(i_tx_valid),
    .o_tx_pop(o_tx_pop), .o_state(o_state)
  );

  // ---------------- environment state ----------------
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_rx_q[$];   // words the sink must see, in order
  logic [17:0] exp_tx_q[$];   // words the host must see, in order
  logic [17:0] ft_rx_q[$];    // FT600 host->FPGA FIFO contents
  logic [17:0] src_q[$];      // on-chip TX source contents
  logic txe_knob = 1'b1, afull_knob = 1'b0, rxf_block = 1'b0;
  int pops = 0, wr_cycles = 0, rx_pulses = 0, tx_words = 0;
  int burst_type_q[$], burst_len_q[$];
  int cur_type = 0, cur_len = 0, idle_run = 0, last_gap = 0;
  bit have_prev = 0, exact_gap = 0;
  logic prev_rd_n = 1'b1, prev_oe_n = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    i_ft_rxf_n = rxf_block || (ft_rx_q.size() == 0);
    if (ft_rx_q.size() != 0) {i_ft_be, i_ft_data} = ft_rx_q[0];
    else {i_ft_be, i_ft_data} = '0;
    i_tx_valid = (src_q.size() != 0);
    if (src_q.size() != 0) {i_tx_be, i_tx_data} = src_q[0];
    else {i_tx_be, i_tx_data} = '0;
    i_ft_txe_n = txe_knob;
    i_rx_afull = afull_knob;
  endtask

  task automatic push_rx(input logic [17:0] w);
    ft_rx_q.push_back(w);
    exp_rx_q.push_back(w);
  endtask

  task automatic push_tx(input logic [17:0] w);
    src_q.push_back(w);
    exp_tx_q.push_back(w);
  endtask

  task automatic clear_bursts();
    burst_type_q.delete();
    burst_len_q.delete();
    cur_len = 0; idle_run = 0; last_gap = 0; have_prev = 0;
  endtask

  // One clock: observe at the negedge, let the edge happen, then update the
  // device/source models and re-drive the inputs #1 after the edge.
  task automatic step();
    bit rd_fire, wr_fire, pop_now, idle;
    int t;
    logic [17:0] e;
    @(negedge clk);
    rd_fire = !o_ft_rd_n && !i_ft_rxf_n;
    wr_fire = !o_ft_wr_n && !i_ft_txe_n;
    pop_now = o_tx_pop;
    idle    = !o_ft_drive && o_ft_oe_n && o_ft_rd_n && o_ft_wr_n;

    check("drive_with_oe", 32'(o_ft_drive && !o_ft_oe_n), 32'd0);
    if (!o_ft_rd_n) check("rd_needs_oe", 32'(o_ft_oe_n), 32'd0);
    if (!o_ft_rd_n && prev_rd_n) check("oe_leads_rd", 32'(prev_oe_n), 32'd0);
    if (pop_now) check("pop_nonempty", 32'(src_q.size() != 0), 32'd1);

    // sink scoreboard
    if (o_rx_valid) begin
      rx_pulses++;
      if (exp_rx_q.size() == 0) check("rx_extra", 32'd1, 32'd0);
      else begin
        e = exp_rx_q.pop_front();
        check("rx_word", 32'({o_rx_be, o_rx_data}), 32'(e));
      end
    end
    // host-side scoreboard
    if (wr_fire) begin
      tx_words++;
      check("tx_drive", 32'(o_ft_drive), 32'd1);
      if (exp_tx_q.size() == 0) check("tx_extra", 32'd1, 32'd0);
      else begin
        e = exp_tx_q.pop_front();
        check("tx_word", 32'({o_ft_be, o_ft_data}), 32'(e));
      end
    end
    if (!o_ft_wr_n) wr_cycles++;

    // burst bookkeeping: a burst is the run of transfers between idle cycles
    if (idle) begin
      if (cur_len > 0) begin
        check("burst_max", 32'(cur_len <= MAXB), 32'd1);
        burst_type_q.push_back(cur_type);
        burst_len_q.push_back(cur_len);
        cur_len = 0;
      end
      idle_run++;
    end else begin
      if (idle_run > 0) last_gap = idle_run;
      idle_run = 0;
    end
    t = rd_fire ? 1 : (wr_fire ? 2 : 0);
    if (t != 0) begin
      if (cur_len == 0) begin
        if (have_prev) begin
          if (exact_gap) check("turn_gap", 32'(last_gap), 32'(TURNC + 1));
          else check("turn_gap_min", 32'(last_gap >= TURNC + 1), 32'd1);
        end
        cur_type = t;
        have_prev = 1;
      end else begin
        check("burst_mix", 32'(t), 32'(cur_type));
      end
      cur_len++;
    end
    prev_rd_n = o_ft_rd_n;
    prev_oe_n = o_ft_oe_n;

    @(posedge clk);
    #1;
    if (rd_fire && ft_rx_q.size() != 0) void'(ft_rx_q.pop_front());
    if (pop_now) begin
      pops++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_rx_q.size() != 0 || exp_tx_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    repeat (8) step();
  endtask

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, further;
    bit found;
    logic [17:0] w;

    i_rst_n = 1'b0;
    drive_inputs();
    repeat (3) @(negedge clk);
    check("rst_oe_n", 32'(o_ft_oe_n), 32'd1);
    check("rst_rd_n", 32'(o_ft_rd_n), 32'd1);
    check("rst_wr_n", 32'(o_ft_wr_n), 32'd1);
    check("rst_drive", 32'(o_ft_drive), 32'd0);
    check("rst_ft_data", 32'({o_ft_be, o_ft_data}), 32'd0);
    check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_tx_pop", 32'(o_tx_pop), 32'd0);
    i_rst_n = 1'b1;
    repeat (3) step();

    // RX only: ten words, split into MAXB-sized bursts
    clear_bursts();
    for (int i = 1; i <= 10; i++) push_rx({2'b11, 16'(i)});
    drive_inputs();
    drain("rx_only_drain", 300);
    check("rx_only_pulses", 32'(rx_pulses), 32'd10);
    check("rx_only_bursts", 32'(burst_len_q.size()), 32'd3);
    if (burst_len_q.size() == 3) begin
      check("rx_only_len0", 32'(burst_len_q[0]), 32'd4);
      check("rx_only_len1", 32'(burst_len_q[1]), 32'd4);
      check("rx_only_len2", 32'(burst_len_q[2]), 32'd2);
      check("rx_only_type", 32'(burst_type_q[2]), 32'd1);
    end
    check("rx_only_idle", 32'(o_state), 32'd0);

    // TX only: five words, txe_n low throughout
    pops = 0; wr_cycles = 0;
    txe_knob = 1'b0;
    for (int i = 0; i < 5; i++) push_tx({2'b11, 16'hA000 + 16'(i)});
    drive_inputs();
    drain("tx_only_drain", 300);
    check("tx_only_pops", 32'(pops), 32'd5);
    check("tx_only_wr_cycles", 32'(wr_cycles), 32'd5);

    // TX backpressure: txe_n rises while word 3 is on the bus
    base = tx_words;
    for (int i = 0; i < 6; i++) push_tx({2'($urandom_range(1, 3)), 16'hB000 + 16'(i)});
    drive_inputs();
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (!o_ft_wr_n && (tx_words - base) == 2) found = 1;
    end
    check("bp_word3_on_bus", 32'(found), 32'd1);
    txe_knob = 1'b1;
    drive_inputs();
    repeat (10) step();
    check("bp_stalled_words", 32'(tx_words - base), 32'd2);
    check("bp_released", 32'(o_ft_drive), 32'd0);
    check("bp_idle", 32'(o_state), 32'd0);
    txe_knob = 1'b0;
    drive_inputs();
    drain("bp_drain", 300);
    check("bp_total", 32'(tx_words - base), 32'd6);

    // Contention: both paths always requesting
    clear_bursts();
    exact_gap = 1;
    for (int i = 0; i < 16; i++) begin
      push_rx({2'($urandom_range(0, 3)), 16'($urandom)});
      push_tx({2'($urandom_range(0, 3)), 16'($urandom)});
    end
    drive_inputs();
    drain("cont_drain", 600);
    exact_gap = 0;
    check("cont_bursts", 32'(burst_len_q.size()), 32'd8);
    for (int i = 0; i < burst_len_q.size(); i++) begin
      check("cont_len", 32'(burst_len_q[i]), 32'(MAXB));
      if (i > 0) check("cont_alternate", 32'(burst_type_q[i] != burst_type_q[i-1]), 32'd1);
    end

    // Sink afull after three words of an RX burst
    base = rx_pulses;
    for (int i = 0; i < 8; i++) push_rx({2'b01, 16'h5000 + 16'(i)});
    drive_inputs();
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if ((rx_pulses - base) == 3) found = 1;
    end
    check("afull_three_seen", 32'(found), 32'd1);
    afull_knob = 1'b1;
    drive_inputs();
    repeat (12) step();
    further = rx_pulses - base - 3;
    check("afull_further_le2", 32'(further <= 2), 32'd1);
    check("afull_rd_high", 32'(o_ft_rd_n), 32'd1);
    afull_knob = 1'b0;
    drive_inputs();
    drain("afull_drain", 300);
    check("afull_total", 32'(rx_pulses - base), 32'd8);

    // Reset in the middle of a TX burst
    for (int i = 0; i < 6; i++) push_tx({2'b10, 16'hC000 + 16'(i)});
    drive_inputs();
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (!o_ft_wr_n) found = 1;
    end
    check("rst_mid_wr_low", 32'(found), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_wr_n", 32'(o_ft_wr_n), 32'd1);
    check("rst_mid_drive", 32'(o_ft_drive), 32'd0);
    src_q.delete();
    exp_tx_q.delete();
    clear_bursts();
    prev_rd_n = 1'b1; prev_oe_n = 1'b1;
    drive_inputs();
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (6) step();
    check("rst_mid_state", 32'(o_state), 32'd0);
    check("rst_mid_hold_empty", 32'(o_ft_wr_n), 32'd1);
    check("rst_mid_no_drive", 32'(o_ft_drive), 32'd0);
    check("rst_mid_ft_data", 32'({o_ft_be, o_ft_data}), 32'd0);

    // Random traffic with random stalls on every handshake
    for (int i = 0; i < 60; i++) begin
      push_rx({2'($urandom_range(0, 3)), 16'($urandom)});
      w = {2'($urandom_range(0, 3)), 16'($urandom)};
      push_tx(w);
    end
    drive_inputs();
    for (int n = 0; n < 3000 && (exp_rx_q.size() != 0 || exp_tx_q.size() != 0); n++) begin
      txe_knob   = ($urandom_range(0, 3) == 0);
      afull_knob = ($urandom_range(0, 7) == 0);
      rxf_block  = ($urandom_range(0, 4) == 0);
      drive_inputs();
      step();
    end
    txe_knob = 1'b0; afull_knob = 1'b0; rxf_block = 1'b0;
    drive_inputs();
    drain("rand_drain", 1000);
    check("rand_sink_empty", 32'(exp_rx_q.size()), 32'd0);
    check("rand_host_empty", 32'(exp_tx_q.size()), 32'd0);
    check("afull_margin", 32'(RX_AFULL_MARGIN), 32'(2 + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
